// File: rtl/cdc_hs_pkg.sv
// Shared state encoding for the four-phase handshake sender.
// No logic; latency and backpressure are defined by the users of this package.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } hs_state_e;

    localparam int SENT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; pop_data shows the head combinationally.
// Latency: a push is visible at the head one cycle later; a push when full or a pop when empty is ignored.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        push_ok  = push && (level_q < LVL_W'(DEPTH));
        pop_ok   = pop && (level_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so the pointers wrap naturally
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/cdc_hs_sender.sv
// Buffers upstream words and sends each through a four-phase req/ack handshake synchroniser.
// Latency: push edge to hs_valid high is one edge (sampled at the second); in_ready drops only when the buffer is full.
module cdc_hs_sender
    import cdc_hs_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  hs_data,
    output logic              hs_valid,
    input  logic              hs_rcv,
    output logic [LVL_W-1:0]  level,
    output logic              busy,
    output logic [SENT_W-1:0] sent_count,
    output logic              proto_err
);

    hs_state_e         state_q, state_d;
    logic [WIDTH-1:0]  hs_data_q, hs_data_d;
    logic [SENT_W-1:0] sent_count_q, sent_count_d;
    logic              proto_err_q, proto_err_d;
    logic              rst_hold_q, rst_hold_d;
    logic              fifo_pop;
    logic [WIDTH-1:0]  fifo_data;
    logic [LVL_W-1:0]  fifo_level;

    assign in_ready = (fifo_level < LVL_W'(DEPTH));

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .level     (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        hs_data_d    = hs_data_q;
        sent_count_d = sent_count_q;
        proto_err_d  = proto_err_q;
        // a receiver still high from before reset is draining, not misbehaving
        rst_hold_d   = rst_hold_q && hs_rcv;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_rcv) begin
                    if (!rst_hold_q) begin
                        proto_err_d = 1'b1;
                    end
                end else if (fifo_level != '0) begin
                    fifo_pop  = 1'b1;
                    hs_data_d = fifo_data;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (hs_rcv) begin
                    proto_err_d = 1'b1;
                end
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (hs_rcv) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!hs_rcv) begin
                    state_d      = ST_IDLE;
                    sent_count_d = sent_count_q + SENT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hs_data_q    <= '0;
            sent_count_q <= '0;
            proto_err_q  <= 1'b0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            hs_data_q    <= hs_data_d;
            sent_count_q <= sent_count_d;
            proto_err_q  <= proto_err_d;
            rst_hold_q   <= rst_hold_d;
        end
    end

    assign hs_valid   = (state_q == ST_REQ);
    assign hs_data    = hs_data_q;
    assign level      = fifo_level;
    assign busy       = (state_q != ST_IDLE) || (fifo_level != '0);
    assign sent_count = sent_count_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Scoreboard bench for cdc_hs_sender: a driver queues expected words, a monitor checks hs_data and status.
// A responder process plays the synchroniser's receive side with random or fixed delays.
module tb_cdc_hs_sender;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  hs_data;
    logic        hs_valid;
    logic        hs_rcv;
    logic [2:0]  level;
    logic        busy;
    logic [15:0] sent_count;
    logic        proto_err;

    logic        rcv_resp;
    logic        rcv_manual;
    assign hs_rcv = rcv_resp | rcv_manual;

    int         checks;
    int         failures;
    int         cyc;
    logic [7:0] exp_q[$];
    int         pushed;
    int         popped;
    int         done_cnt;
    int         sent_ofs;
    bit         exp_err;
    bit         mon_en;
    bit         resp_en;
    int         fix_d1;
    int         fix_d2;
    int         full_events;
    int         last_valid_cyc;
    int         push_cyc;
    bit         prev_valid;

    cdc_hs_sender #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hs_data    (hs_data),
        .hs_valid   (hs_valid),
        .hs_rcv     (hs_rcv),
        .level      (level),
        .busy       (busy),
        .sent_count (sent_count),
        .proto_err  (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every falling edge, compare outputs with the scoreboard and counters.
    always @(negedge clk) begin
        if (!mon_en) begin
            popped     = 0;
            prev_valid = 1'b0;
        end else begin
            if (hs_valid) begin
                chk("hs_valid_single_cycle", 32'(prev_valid), 32'(0));
                chk("no_overlap", 32'(popped), 32'(done_cnt));
                if (exp_q.size() == 0) begin
                    chk("unexpected_hs_valid", 32'(1), 32'(0));
                end else begin
                    chk("hs_data", 32'(hs_data), 32'(exp_q.pop_front()));
                end
                popped++;
                last_valid_cyc = cyc;
            end
            prev_valid = hs_valid;
            chk("level", 32'(level), 32'(pushed - popped));
            chk("in_ready", 32'(in_ready), 32'((pushed - popped) < DEPTH));
            chk("sent_count", 32'(sent_count), 32'((done_cnt + sent_ofs) & 32'hFFFF));
            chk("proto_err", 32'(proto_err), 32'(exp_err));
            if (!in_ready) full_events++;
        end
    end

    // Responder: raises rcv d1 cycles after the strobe, holds it d2 cycles, then drops it.
    initial begin
        int d1;
        int d2;
        rcv_resp = 1'b0;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_cnt = 0;
            end else if (resp_en && hs_valid) begin
                d1 = (fix_d1 >= 0) ? fix_d1 : int'($urandom_range(0, 5));
                d2 = (fix_d2 >= 1) ? fix_d2 : int'($urandom_range(1, 5));
                @(posedge clk);
                repeat (d1) @(posedge clk);
                #1 rcv_resp = 1'b1;
                repeat (d2) @(posedge clk);
                #1 rcv_resp = 1'b0;
                @(posedge clk);
                #1 done_cnt++;
            end
        end
    end

    // Called just after a rising edge; records the word when it is accepted.
    task automatic push_word(input logic [7:0] d);
        bit ok = 1'b0;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(d);
                pushed++;
                push_cyc = cyc;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("push_accepted", 32'(ok), 32'(1));
    endtask

    task automatic wait_pop(input int target, input string nm);
        int n = 0;
        while (popped < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_pop_seen"}, 32'(n < 500), 32'(1));
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (!(exp_q.size() == 0 && done_cnt == pushed && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, 32'(n < 3000), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        int p0;
        checks = 0;       failures = 0;
        pushed = 0;       sent_ofs = 0;
        exp_err = 1'b0;   mon_en = 1'b0;
        resp_en = 1'b1;   fix_d1 = -1;    fix_d2 = -1;
        full_events = 0;  last_valid_cyc = 0; push_cyc = 0;
        rcv_manual = 1'b0;
        in_valid = 1'b0;  in_data = '0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_hs_valid", 32'(hs_valid), 32'(0));
        chk("rst_hs_data", 32'(hs_data), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_sent", 32'(sent_count), 32'(0));
        chk("rst_proto_err", 32'(proto_err), 32'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // single word with fixed receiver timing
        fix_d1 = 2; fix_d2 = 3;
        push_word(8'hA5);
        wait_pop(1, "single");
        // strobe must be sampled by the second rising edge after the push edge
        chk("latency", 32'(last_valid_cyc + 1), 32'(push_cyc + 2));
        wait_drain("single");
        chk("single_sent", 32'(sent_count), 32'(1));
        chk("single_busy", 32'(busy), 32'(0));
        chk("single_hold_data", 32'(hs_data), 32'hA5);
        chk("single_pulses", 32'(popped), 32'(1));

        // burst of six against a four-entry buffer
        fix_d1 = 4; fix_d2 = 2;
        f0 = full_events;
        for (int i = 1; i <= 6; i++) push_word(8'(i));
        wait_drain("burst");
        chk("burst_full_seen", 32'(full_events > f0), 32'(1));
        chk("burst_sent", 32'(sent_count), 32'(7));

        // slow acknowledge: no second strobe while waiting
        fix_d1 = 50; fix_d2 = 2;
        p0 = popped;
        push_word(8'h3C);
        wait_pop(p0 + 1, "slow");
        push_word(8'hC3);
        repeat (40) @(negedge clk);
        chk("slow_pulses", 32'(popped), 32'(p0 + 1));
        chk("slow_busy", 32'(busy), 32'(1));
        chk("slow_level", 32'(level), 32'(1));
        fix_d1 = -1; fix_d2 = -1;
        wait_drain("slow");

        // random traffic with random receiver delays
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            push_word(8'($urandom));
        end
        wait_drain("random");
        chk("random_sent", 32'(sent_count), 32'(69));

        // counter wrap
        force dut.sent_count_q = 16'hFFFF;
        sent_ofs = 65535 - done_cnt;
        @(posedge clk);
        #1;
        release dut.sent_count_q;
        @(negedge clk);
        chk("wrap_preload", 32'(sent_count), 32'hFFFF);
        @(posedge clk);
        #1;
        push_word(8'h77);
        wait_drain("wrap");
        chk("wrap_sent", 32'(sent_count), 32'(0));

        // protocol error: receiver high while idle
        rcv_manual = 1'b1;
        @(posedge clk);
        #1 exp_err = 1'b1;
        @(negedge clk);
        chk("proto_set", 32'(proto_err), 32'(1));
        @(posedge clk);
        #1;
        p0 = popped;
        push_word(8'h5A);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("proto_no_req", 32'(popped), 32'(p0));
        chk("proto_level", 32'(level), 32'(1));
        rcv_manual = 1'b0;
        wait_drain("proto");
        chk("proto_sticky", 32'(proto_err), 32'(1));

        // reset while in WAIT_LO with two words buffered
        resp_en = 1'b0;
        p0 = popped;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        wait_pop(p0 + 1, "midrst");
        rcv_manual = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_level", 32'(level), 32'(2));
        chk("midrst_busy", 32'(busy), 32'(1));
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_hs_valid", 32'(hs_valid), 32'(0));
        chk("midrst_hs_data", 32'(hs_data), 32'(0));
        chk("midrst_level0", 32'(level), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        chk("midrst_busy0", 32'(busy), 32'(0));
        chk("midrst_sent", 32'(sent_count), 32'(0));
        chk("midrst_proto_err", 32'(proto_err), 32'(0));
        exp_q.delete();
        pushed   = 0;
        exp_err  = 1'b0;
        sent_ofs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        push_word(8'h99);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("postrst_no_req", 32'(popped), 32'(0));
        chk("postrst_no_err", 32'(proto_err), 32'(0));
        resp_en    = 1'b1;
        rcv_manual = 1'b0;
        wait_drain("postrst");
        chk("postrst_sent", 32'(sent_count), 32'(1));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
